level_event_arbiter: RTL

Converts NUM_EVENTS asynchronous-to-protocol level signals (status flags, done levels) into rising-edge events, latches each as a pending request, and serializes them to a single consumer over a valid/ready handshake with round-robin fairness. It sits in the commctrl fabric between peripheral status levels and the interrupt/message controller, replacing per-signal edge detectors with a shared, loss-reporting event queue.

---
 rtl/level_event_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/level_event_arbiter.sv
// level_event_arbiter
// Turns per-source level signals into rising-edge events and latches each one
// as a pending request. Pending requests go to one consumer over valid/ready,
// using round-robin order. If a new edge arrives while that source is already
// pending, the loss is recorded in a sticky overflow bit.
module level_event_arbiter #(
  parameter  int NUM_EVENTS = 4,
  localparam int ID_W       = $clog2(NUM_EVENTS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_EVENTS-1:0] level,
  input  logic [NUM_EVENTS-1:0] enable,
  input  logic                  evt_ready,
  input  logic [NUM_EVENTS-1:0] clear_overflow,
  output logic                  evt_valid,
  output logic [ID_W-1:0]       evt_id,
  output logic [NUM_EVENTS-1:0] pending,
  output logic [NUM_EVENTS-1:0] overflow
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  logic [NUM_EVENTS-1:0] q1_q;
  logic [NUM_EVENTS-1:0] q2_q;
  logic [NUM_EVENTS-1:0] pending_q;
  logic [NUM_EVENTS-1:0] pending_d;
  logic [NUM_EVENTS-1:0] overflow_q;
  logic [NUM_EVENTS-1:0] overflow_d;
  logic [NUM_EVENTS-1:0] edge_s;
  logic [NUM_EVENTS-1:0] set_s;
  logic [NUM_EVENTS-1:0] accept_vec_s;
  logic                  accept_s;

  logic [0:0]            state_q;
  logic [0:0]            state_d;
  logic                  evt_valid_q;
  logic                  evt_valid_d;
  logic [ID_W-1:0]       evt_id_q;
  logic [ID_W-1:0]       evt_id_d;
  logic [ID_W-1:0]       rr_ptr_q;
  logic [ID_W-1:0]       rr_ptr_d;

  logic                  hi_found_s;
  logic [ID_W-1:0]       hi_id_s;
  logic                  lo_found_s;
  logic [ID_W-1:0]       lo_id_s;
  logic                  sel_found_s;
  logic [ID_W-1:0]       sel_id_s;

  // A 0->1 transition between the two sync stages is one event.
  // The enable input gates only the creation of new pending bits.
  assign edge_s   = q1_q & ~q2_q;
  assign set_s    = edge_s & enable;
  assign accept_s = evt_valid_q & evt_ready;

  // Decode the handshake into a one-hot "accepted this cycle" vector.
  always_comb begin
    accept_vec_s = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (accept_s && (evt_id_q == ID_W'(i))) begin
        accept_vec_s[i] = 1'b1;
      end else begin
        accept_vec_s[i] = 1'b0;
      end
    end
  end

  // A new edge wins over a same-cycle accept, so the fresh event stays queued.
  // A set of an overflow bit wins over its clear.
  always_comb begin
    pending_d  = set_s | (pending_q & ~accept_vec_s);
    overflow_d = (set_s & pending_q & ~accept_vec_s) | (overflow_q & ~clear_overflow);
  end

  // Round-robin scan: find the lowest pending index at or above rr_ptr.
  // If there is none, fall back to the lowest pending index overall.
  always_comb begin
    hi_found_s = 1'b0;
    hi_id_s    = '0;
    lo_found_s = 1'b0;
    lo_id_s    = '0;
    for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        lo_found_s = 1'b1;
        lo_id_s    = ID_W'(i);
        if (ID_W'(i) >= rr_ptr_q) begin
          hi_found_s = 1'b1;
          hi_id_s    = ID_W'(i);
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    sel_found_s = lo_found_s;
    if (hi_found_s) begin
      sel_id_s = hi_id_s;
    end else begin
      sel_id_s = lo_id_s;
    end
  end

  // Two-state offer FSM.
  // IDLE latches a winner; OFFER holds it stable until it is accepted.
  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    rr_ptr_d    = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s) begin
          state_d     = ST_OFFER;
          evt_valid_d = 1'b1;
          evt_id_d    = sel_id_s;
        end else begin
          state_d     = ST_IDLE;
          evt_valid_d = 1'b0;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          state_d     = ST_IDLE;
          evt_valid_d = 1'b0;
          if (evt_id_q == ID_W'(NUM_EVENTS - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = evt_id_q + ID_W'(1);
          end
        end else begin
          state_d     = ST_OFFER;
          evt_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  // Reset drops any offer that is in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q1_q        <= '0;
      q2_q        <= '0;
      pending_q   <= '0;
      overflow_q  <= '0;
      rr_ptr_q    <= '0;
      state_q     <= ST_IDLE;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
    end else begin
      q1_q        <= level;
      q2_q        <= q1_q;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      rr_ptr_q    <= rr_ptr_d;
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule
